// File: rtl/alu_sequencer.sv
// alu_sequencer: control FSM for the 4-bit accumulating ALU datapath.
// Latches one operation on Start, optionally clears the datapath,
// applies the operation for exactly Count edges, captures the 8-bit
// result and pulses Done for one cycle.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for Start; datapath held
// CLEAR   | one cycle with datapath reset asserted
// RUN     | datapath applies latched function/operand every edge
// CAPTURE | datapath held; result register loads AluResult
// DONE    | one-cycle Done pulse; Start ignored
module alu_sequencer #(
    parameter int         CNT_W   = 4,
    parameter logic [2:0] HOLD_FN = 3'b111
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [2:0]       i_op_function,
    input  logic [3:0]       i_op_data,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_clear,
    input  logic [7:0]       i_alu_result,
    output logic [2:0]       o_alu_function,
    output logic [3:0]       o_alu_data,
    output logic             o_alu_reset_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_result
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_rem;
    logic [2:0]       r_fn;
    logic [3:0]       r_data;
    logic [7:0]       r_result;

    logic             w_in_run;
    logic             w_in_clear;

    // Next-state decode; Start only matters in IDLE, so requests made
    // while busy are simply dropped.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_clear)
                        w_next_state = S_CLEAR;
                    else if (i_count != CNT_ZERO)
                        w_next_state = S_RUN;
                    else
                        w_next_state = S_CAPTURE;
                end
            end
            S_CLEAR: begin
                if (r_rem != CNT_ZERO)
                    w_next_state = S_RUN;
                else
                    w_next_state = S_CAPTURE;
            end
            S_RUN: begin
                if (r_rem == CNT_ONE)
                    w_next_state = S_CAPTURE;
            end
            S_CAPTURE: w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Operation latch and repeat down-counter; the counter reaching one
    // in RUN marks the last datapath update.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rem  <= '0;
            r_fn   <= 3'b000;
            r_data <= 4'h0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_rem  <= i_count;
                r_fn   <= i_op_function;
                r_data <= i_op_data;
            end else if (r_state == S_RUN) begin
                r_rem <= r_rem - CNT_ONE;
            end
        end
    end

    // Result capture; the value is held until the next CAPTURE.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_result <= 8'h00;
        else if (r_state == S_CAPTURE)
            r_result <= i_alu_result;
    end

    assign w_in_run   = (r_state == S_RUN);
    assign w_in_clear = (r_state == S_CLEAR);

    // Datapath drive: the latched operation reaches the datapath only in
    // RUN, everywhere else it holds. Reset also clears the datapath on
    // its next edge, hence the combinational OR with i_reset.
    always_comb begin
        o_alu_function = w_in_run ? r_fn : HOLD_FN;
        o_alu_data     = w_in_run ? r_data : 4'h0;
        o_alu_reset_b  = ~(i_reset | w_in_clear);
    end

    // Host-side status.
    always_comb begin
        o_busy   = w_in_clear | w_in_run | (r_state == S_CAPTURE);
        o_done   = (r_state == S_DONE);
        o_result = r_result;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the
// accumulating ALU datapath (001: A+B, 101: {A,B}, others hold).
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op_fn;
    logic [3:0] op_data;
    logic [3:0] count;
    logic       clear;
    logic [7:0] alu_result;
    logic [2:0] alu_fn;
    logic [3:0] alu_data;
    logic       alu_reset_b;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    alu_sequencer #(.CNT_W(4), .HOLD_FN(3'b111)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_op_function  (op_fn),
        .i_op_data      (op_data),
        .i_count        (count),
        .i_clear        (clear),
        .i_alu_result   (alu_result),
        .o_alu_function (alu_fn),
        .o_alu_data     (alu_data),
        .o_alu_reset_b  (alu_reset_b),
        .o_busy         (busy),
        .o_done         (done),
        .o_result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: 8-bit register, sync active-low reset, B = reg[3:0].
    always_ff @(posedge clk) begin
        if (!alu_reset_b)
            alu_result <= 8'h00;
        else begin
            case (alu_fn)
                3'b001:  alu_result <= {4'h0, alu_data} + {4'h0, alu_result[3:0]};
                3'b101:  alu_result <= {alu_data, alu_result[3:0]};
                default: alu_result <= alu_result;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one job; edges = edge index (accept edge = 0) after which Done
    // is seen, busy_cyc = number of Busy cycles before Done.
    task automatic run_job(input logic clr, input logic [2:0] fn, input logic [3:0] d,
                           input logic [3:0] cnt, output int edges, output int busy_cyc);
        clear   = clr;
        op_fn   = fn;
        op_data = d;
        count   = cnt;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        edges    = 0;
        busy_cyc = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cyc++;
            tick();
            edges++;
        end
    endtask

    int edges, busy_cyc, done_cnt, run_cyc;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        op_fn   = 3'b000;
        op_data = 4'h0;
        count   = 4'h0;
        clear   = 1'b0;
        #1;
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_alu_fn",  alu_fn, 3'b111);
        check("rst_alu_dat", alu_data, 4'h0);
        check("rst_reset_b", alu_reset_b, 0);
        check("rst_result",  result, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("idle_reset_b", alu_reset_b, 1);
        check("idle_dp_zero", alu_result, 8'h00);

        // Job 1: clear, add 5 four times -> 0x14.
        clear = 1'b1; op_fn = 3'b001; op_data = 4'h5; count = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("j1_clear_busy",    busy, 1);
        check("j1_clear_reset_b", alu_reset_b, 0);
        check("j1_clear_fn",      alu_fn, 3'b111);
        tick();
        check("j1_run_fn",   alu_fn, 3'b001);
        check("j1_run_data", alu_data, 4'h5);
        check("j1_dp_e1",    alu_result, 8'h00);
        tick();
        check("j1_dp_e2",    alu_result, 8'h05);
        tick();
        check("j1_dp_e3",    alu_result, 8'h0A);
        tick();
        check("j1_dp_e4",    alu_result, 8'h0F);
        tick();
        check("j1_dp_e5",    alu_result, 8'h14);
        check("j1_cap_fn",   alu_fn, 3'b111);
        check("j1_cap_busy", busy, 1);
        check("j1_no_done",  done, 0);
        tick();
        check("j1_done_e6",  done, 1);
        check("j1_done_busy", busy, 0);
        check("j1_result",   result, 8'h14);
        tick();
        check("j1_done_once", done, 0);
        check("j1_hold",     alu_result, 8'h14);

        // Job 1 again through the helper to measure Busy length: 2+Count.
        // (re-clears, so the datapath ends at 0x14 again)
        run_job(1'b1, 3'b001, 4'h5, 4'd4, edges, busy_cyc);
        check("j1b_edges", edges, 6);
        check("j1b_busy",  busy_cyc, 6);
        tick();

        // Job 2: no clear, add 1 twice from 0x14 (B=4) -> 0x05, 0x06.
        run_job(1'b0, 3'b001, 4'h1, 4'd2, edges, busy_cyc);
        check("j2_edges",  edges, 3);
        check("j2_busy",   busy_cyc, 3);
        check("j2_result", result, 8'h06);
        tick();

        // Job 3a: clear, {A,B} with A=A three times -> 0xA0.
        run_job(1'b1, 3'b101, 4'hA, 4'd3, edges, busy_cyc);
        check("j3a_edges",  edges, 5);
        check("j3a_result", result, 8'hA0);
        tick();

        // Job 3b: Count=0, no clear -> straight to capture, datapath untouched.
        run_job(1'b0, 3'b001, 4'h3, 4'd0, edges, busy_cyc);
        check("j3b_edges",  edges, 1);
        check("j3b_busy",   busy_cyc, 1);
        check("j3b_result", result, 8'hA0);
        check("j3b_dp",     alu_result, 8'hA0);
        tick();

        // Job 4: Start held high every cycle, inputs churned after accept.
        // From 0xA0 (B=0), add 1 five times -> 0x05.
        clear = 1'b0; op_fn = 3'b001; op_data = 4'h1; count = 4'd5; start = 1'b1;
        tick();
        op_fn = 3'b101; op_data = 4'h7; count = 4'd9; clear = 1'b1;
        done_cnt = 0;
        run_cyc  = 0;
        edges    = 0;
        for (int i = 0; i < 20; i++) begin
            if (alu_fn != 3'b111) run_cyc++;
            if (done) begin
                done_cnt++;
                if (edges == 0) edges = i;
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("j4_done_cnt", done_cnt, 1);
        check("j4_done_e",   edges, 6);
        check("j4_run_cyc",  run_cyc, 5);
        check("j4_result",   result, 8'h05);
        check("j4_idle_fn",  alu_fn, 3'b111);

        // Job 5: Count=6, Reset in 2nd RUN cycle.
        clear = 1'b0; op_fn = 3'b001; op_data = 4'h2; count = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("j5_run2_fn", alu_fn, 3'b001);
        rst = 1'b1;
        #1;
        check("j5_rst_busy",    busy, 0);
        check("j5_rst_done",    done, 0);
        check("j5_rst_fn",      alu_fn, 3'b111);
        check("j5_rst_reset_b", alu_reset_b, 0);
        check("j5_rst_result",  result, 8'h00);
        tick();
        check("j5_dp_cleared", alu_result, 8'h00);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        check("j5_no_activity", done_cnt, 0);
        check("j5_result_kept", result, 8'h00);

        // Job 6: single add after reset -> 0x03.
        run_job(1'b0, 3'b001, 4'h3, 4'd1, edges, busy_cyc);
        check("j6_edges",  edges, 2);
        check("j6_result", result, 8'h03);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
